// File: rtl/enc_input_frontend_if.sv
// Pin-side bundle for the encoder/button input frontend.
//   enc_a_i, enc_b_i, btn_n_i : raw asynchronous pins (btn_n_i low = pressed)
//   step_o, dir_o, quad_err_o : detent step pulse, its direction, illegal-jump pulse
//   btn_o, btn_press_o, btn_release_o, btn_long_o : debounced level and event pulses
// slave  = the frontend itself, master = whoever drives the pins and consumes events.
interface enc_input_frontend_if;
  logic enc_a_i;
  logic enc_b_i;
  logic btn_n_i;
  logic step_o;
  logic dir_o;
  logic quad_err_o;
  logic btn_o;
  logic btn_press_o;
  logic btn_release_o;
  logic btn_long_o;

  modport master (
    output enc_a_i, enc_b_i, btn_n_i,
    input  step_o, dir_o, quad_err_o, btn_o, btn_press_o, btn_release_o, btn_long_o
  );

  modport slave (
    input  enc_a_i, enc_b_i, btn_n_i,
    output step_o, dir_o, quad_err_o, btn_o, btn_press_o, btn_release_o, btn_long_o
  );
endinterface

// File: rtl/enc_input_frontend.sv
// Input conditioning between the ui_in pins and the core logic.
//   - 2-FF synchronisers on encoder A/B and the pushbutton
//   - glitch filter on {B,A}, quadrature decode into detent steps with direction
//   - button debounce into a level plus press / release / long-press pulses
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active high
//   bus  : enc_input_frontend_if.slave (pins in, conditioned events out)
module enc_input_frontend #(
  parameter int FILT_CYCLES      = 4,
  parameter int STEPS_PER_DETENT = 4,
  parameter int DEB_CYCLES       = 16,
  parameter int LONG_CYCLES      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  enc_input_frontend_if.slave  bus
);

  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  // Accumulator value one transition short of a detent in each direction.
  localparam logic signed [3:0] ACC_TOP = 4'(STEPS_PER_DETENT - 1);
  localparam logic signed [3:0] ACC_BOT = 4'(1 - STEPS_PER_DETENT);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG} btn_state_e;

  // Gray {B,A} -> position 0..3 along the CW order 00,01,11,10.
  function automatic logic [1:0] quad_pos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction

  // ---------------- encoder path ----------------
  logic [1:0]        esync1_q, esync1_d, esync2_q, esync2_d;
  logic [1:0]        cand_q, cand_d, filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              primed_q, primed_d;
  logic signed [3:0] acc_q, acc_d;
  logic              step_q, step_d, dir_q, dir_d, err_q, err_d;
  logic [1:0]        pos_delta;

  always_comb begin
    esync1_d    = {bus.enc_b_i, bus.enc_a_i};
    esync2_d    = esync1_q;
    cand_d      = cand_q;
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    fcnt_d      = fcnt_q;
    primed_d    = primed_q;
    acc_d       = acc_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = 1'b0;
    pos_delta   = quad_pos(filt_q) - quad_pos(filt_prev_q);

    // Glitch filter: a level must persist FILT_CYCLES cycles to be accepted.
    if (esync2_q != cand_q) begin
      cand_d = esync2_q;
      fcnt_d = '0;
    end else if (fcnt_q == FW'(FILT_CYCLES - 1)) begin
      filt_d = cand_q;
      // First acceptance only establishes the reference position; loading
      // prev too hides it from the decoder so a non-00 rest state is silent.
      if (!primed_q) begin
        primed_d    = 1'b1;
        filt_prev_d = cand_q;
      end
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end

    // Decode one cycle after filt moves; pulses leave straight from flops.
    if (primed_q && (filt_q != filt_prev_q)) begin
      unique case (pos_delta)
        2'd1: begin
          if (acc_q == ACC_TOP) begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            acc_d  = '0;
          end else begin
            acc_d = acc_q + 4'sd1;
          end
        end
        2'd3: begin
          if (acc_q == ACC_BOT) begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            acc_d  = '0;
          end else begin
            acc_d = acc_q - 4'sd1;
          end
        end
        default: begin
          err_d = 1'b1;
          acc_d = '0;
        end
      endcase
    end
  end

  // ---------------- button path ----------------
  logic          bsync1_q, bsync1_d, bsync2_q, bsync2_d;
  logic          btn_q, btn_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  btn_state_e    state_q, state_d;
  logic          press_q, press_d, rel_q, rel_d, long_q, long_d;
  logic          btn_lvl;

  always_comb begin
    bsync1_d = bus.btn_n_i;
    bsync2_d = bsync1_q;
    btn_lvl  = ~bsync2_q;
    btn_d    = btn_q;
    dcnt_d   = '0;
    if (btn_lvl != btn_q) begin
      if (dcnt_q == DW'(DEB_CYCLES - 1)) begin
        btn_d  = btn_lvl;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (btn_q) begin
          press_d = 1'b1;
          lcnt_d  = '0;
          state_d = S_PRESSED;
        end
      end
      S_PRESSED: begin
        // Release is checked first so it always beats a long press.
        if (!btn_q) begin
          rel_d   = 1'b1;
          state_d = S_IDLE;
        end else if (lcnt_q == LW'(LONG_CYCLES - 1)) begin
          long_d  = 1'b1;
          state_d = S_LONG;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      S_LONG: begin
        if (!btn_q) begin
          rel_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      esync1_q    <= '0;
      esync2_q    <= '0;
      cand_q      <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      fcnt_q      <= '0;
      primed_q    <= 1'b0;
      acc_q       <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      bsync1_q    <= 1'b1;
      bsync2_q    <= 1'b1;
      btn_q       <= 1'b0;
      dcnt_q      <= '0;
      lcnt_q      <= '0;
      state_q     <= S_IDLE;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      esync1_q    <= esync1_d;
      esync2_q    <= esync2_d;
      cand_q      <= cand_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      fcnt_q      <= fcnt_d;
      primed_q    <= primed_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      bsync1_q    <= bsync1_d;
      bsync2_q    <= bsync2_d;
      btn_q       <= btn_d;
      dcnt_q      <= dcnt_d;
      lcnt_q      <= lcnt_d;
      state_q     <= state_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
    end
  end

  assign bus.step_o        = step_q;
  assign bus.dir_o         = dir_q;
  assign bus.quad_err_o    = err_q;
  assign bus.btn_o         = btn_q;
  assign bus.btn_press_o   = press_q;
  assign bus.btn_release_o = rel_q;
  assign bus.btn_long_o    = long_q;

endmodule

// File: tb/tb_enc_input_frontend.sv
module tb_enc_input_frontend;
  localparam int FILT = 4;
  localparam int N    = 4;
  localparam int DEB  = 16;
  localparam int LONG = 64;
  localparam int ENC_LAT = FILT + 4;
  localparam int BTN_LAT = DEB + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enc_input_frontend_if bus ();

  enc_input_frontend #(
    .FILT_CYCLES(FILT), .STEPS_PER_DETENT(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_STEP, K_ERR, K_PRESS, K_REL, K_LONG} kind_e;
  typedef struct {
    kind_e kind;
    logic  dir;
    int    lo;
    int    hi;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input kind_e k, input logic d, input int lo, input int hi);
    exp_t e;
    e.kind = k; e.dir = d; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  // Monitor: every pulse the DUT shows must match the oldest expected event.
  task automatic seen(input kind_e k, input logic d);
    exp_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s dir=%0b at cycle %0d, expected none", k.name(), d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || cyc < e.lo || cyc > e.hi || (k == K_STEP && d !== e.dir)) begin
        n_fail++;
        $display("FAIL event_match: got %s dir=%0b cycle %0d, expected %s dir=%0b cycle %0d..%0d",
                 k.name(), d, cyc, e.kind.name(), e.dir, e.lo, e.hi);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.step_o)        seen(K_STEP, bus.dir_o);
      if (bus.quad_err_o)    seen(K_ERR, 1'b0);
      if (bus.btn_press_o)   seen(K_PRESS, 1'b0);
      if (bus.btn_long_o)    seen(K_LONG, 1'b0);
      if (bus.btn_release_o) seen(K_REL, 1'b0);
    end
  end

  // ev: 0 none, 1 step expected, 2 quad error expected
  task automatic enc_step(input logic [1:0] ba, input int hold, input int ev, input logic d);
    int t0;
    @(posedge clk); #1;
    {bus.enc_b_i, bus.enc_a_i} = ba;
    t0 = cyc;
    if (ev == 1) expect_evt(K_STEP, d, t0 + ENC_LAT, t0 + ENC_LAT);
    if (ev == 2) expect_evt(K_ERR, 1'b0, t0 + ENC_LAT, t0 + ENC_LAT);
    repeat (hold - 1) @(posedge clk);
  endtask

  function automatic logic [6:0] all_outs();
    return {bus.step_o, bus.dir_o, bus.quad_err_o, bus.btn_o,
            bus.btn_press_o, bus.btn_release_o, bus.btn_long_o};
  endfunction

  logic [1:0] cw_seq  [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] ccw_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] cw_from11 [2] = '{2'b10, 2'b00};
  logic [1:0] cw_from00 [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.enc_a_i = 1'b1; bus.enc_b_i = 1'b1; bus.btn_n_i = 1'b1;
    rst = 1'b1;

    // 1: reset with pins at 11 - no error, no step, all outputs low
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("t1_outputs_idle", 32'(all_outs()), 32'h0);

    // Clean start at 00 for the rotation tests
    rst = 1'b1; bus.enc_a_i = 1'b0; bus.enc_b_i = 1'b0;
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);

    // 2: two CW detents
    for (int i = 0; i < 8; i++) enc_step(cw_seq[i], 10, (i == 3 || i == 7) ? 1 : 0, 1'b1);
    #1 chk("t2_dir_cw", 32'(bus.dir_o), 32'h1);

    // 3: one CCW detent, then a reversal mid-detent
    for (int i = 0; i < 4; i++) enc_step(ccw_seq[i], 10, (i == 3) ? 1 : 0, 1'b0);
    #1 chk("t3_dir_ccw", 32'(bus.dir_o), 32'h0);
    enc_step(2'b01, 10, 0, 1'b0);
    enc_step(2'b00, 10, 0, 1'b0);

    // 4: 2-cycle glitch on A is filtered; then an illegal 00->11 jump
    enc_step(2'b01, 2, 0, 1'b0);
    enc_step(2'b00, 10, 0, 1'b0);
    enc_step(2'b11, 10, 2, 1'b0);
    #1 chk("t4_dir_unchanged", 32'(bus.dir_o), 32'h0);

    // 5: bouncy press, long hold, release
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 bus.btn_n_i = logic'(i % 2);
      repeat (2) @(posedge clk);
    end
    @(posedge clk); #1 bus.btn_n_i = 1'b0;
    t = cyc;
    expect_evt(K_PRESS, 1'b0, t + BTN_LAT, t + BTN_LAT);
    expect_evt(K_LONG, 1'b0, t + BTN_LAT + LONG, t + BTN_LAT + LONG);
    repeat (49) @(posedge clk); #1;
    chk("t5_btn_level_held", 32'(bus.btn_o), 32'h1);
    repeat (50) @(posedge clk);
    @(posedge clk); #1 bus.btn_n_i = 1'b1;
    t = cyc;
    expect_evt(K_REL, 1'b0, t + 17, t + 19);
    repeat (30) @(posedge clk); #1;
    chk("t5_btn_level_released", 32'(bus.btn_o), 32'h0);

    // 6: reset with acc=2 and during a held press
    for (int i = 0; i < 2; i++) enc_step(cw_from11[i], 10, 0, 1'b0);
    @(posedge clk); #1 bus.btn_n_i = 1'b0;
    t = cyc;
    expect_evt(K_PRESS, 1'b0, t + BTN_LAT, t + BTN_LAT);
    repeat (24) @(posedge clk); #1;
    chk("t6_btn_pressed_before_rst", 32'(bus.btn_o), 32'h1);
    rst = 1'b1; bus.btn_n_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("t6_outputs_in_reset", 32'(all_outs()), 32'h0);
    rst = 1'b0;
    repeat (80) @(posedge clk); #1;
    chk("t6_outputs_after_reset", 32'(all_outs()), 32'h0);
    for (int i = 0; i < 4; i++) enc_step(cw_from00[i], 10, (i == 3) ? 1 : 0, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("t6_dir_cw", 32'(bus.dir_o), 32'h1);

    chk("events_outstanding", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
